// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with single outstanding imem read and pc/instr FIFO
module fetch_unit #(
    parameter int AW    = 16,
    parameter int IW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    output logic          pc_load,
    output logic [AW-1:0] pc_in,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_rvalid,
    input  logic [IW-1:0] imem_rdata,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] req_pc_q, req_pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0] fifo_pc_q    [DEPTH];
    logic [IW-1:0] fifo_instr_q [DEPTH];

    logic          push;
    logic          pop;
    logic          have_space;
    logic          load;
    logic [AW-1:0] load_pc;
    logic          req;
    logic [AW-1:0] addr;

    assign have_space = (count_q < CW'(DEPTH));
    assign pop        = (count_q != '0) && instr_ready;

    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        load     = 1'b1;
        load_pc  = pc;
        req      = 1'b0;
        addr     = '0;

        case (state_q)
            S_IDLE: begin
                if (have_space) begin
                    req      = 1'b1;
                    addr     = pc;
                    req_pc_d = pc;
                    load     = 1'b0;
                    load_pc  = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Redirect overrides everything: steer the pc, cancel issue, and orphan any in-flight read.
        if (redirect) begin
            load     = 1'b1;
            load_pc  = redirect_pc;
            req      = 1'b0;
            addr     = '0;
            push     = 1'b0;
            req_pc_d = req_pc_q;
            case (state_q)
                S_WAIT:    state_d = imem_rvalid ? S_IDLE : S_DISCARD;
                S_DISCARD: state_d = imem_rvalid ? S_IDLE : S_DISCARD;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            req_pc_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only exposed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= req_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

    assign pc_load     = reset & load;
    assign pc_in       = reset ? load_pc : '0;
    assign imem_req    = reset & req;
    assign imem_addr   = reset ? addr : '0;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit with pc block and imem models
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        pc_load;
    logic [15:0] pc_in;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [15:0] instr_pc;

    logic        auto_en;
    logic        auto_rv;
    logic [31:0] auto_data;
    logic        man_rv;
    logic [31:0] man_data;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.AW(16), .IW(32), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_load     (pc_load),
        .pc_in       (pc_in),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    always #5 clk = ~clk;

    // pc block: load or increment
    always @(posedge clk or negedge reset) begin
        if (!reset)       pc <= 16'h0;
        else if (pc_load) pc <= pc_in;
        else              pc <= pc + 16'h1;
    end

    // imem with latency 1; data = C0DE_<addr>
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            auto_rv   <= 1'b0;
            auto_data <= 32'h0;
        end else begin
            auto_rv   <= imem_req;
            auto_data <= {16'hC0DE, imem_addr};
        end
    end

    assign imem_rvalid = auto_en ? auto_rv : man_rv;
    assign imem_rdata  = auto_en ? auto_data : man_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        instr_ready = 1'b0;
        man_rv      = 1'b0;
        man_data    = 32'h0;
        step();
        step();
    endtask

    task automatic release_reset();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        auto_en = 1'b1;
        hold_reset();
        check("rst_pc_load", 64'(pc_load), 64'h0);
        check("rst_pc_in", 64'(pc_in), 64'h0);
        check("rst_imem_req", 64'(imem_req), 64'h0);
        check("rst_imem_addr", 64'(imem_addr), 64'h0);
        check("rst_instr_valid", 64'(instr_valid), 64'h0);
        check("rst_instr", 64'(instr), 64'h0);
        check("rst_instr_pc", 64'(instr_pc), 64'h0);

        // 1: streaming at L=1, one instruction every two cycles
        instr_ready = 1'b1;
        release_reset();
        check("t1_req0", 64'(imem_req), 64'h1);
        check("t1_addr0", 64'(imem_addr), 64'h0);
        check("t1_pcload0", 64'(pc_load), 64'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("t1_wait_req", 64'(imem_req), 64'h0);
            check("t1_wait_hold", 64'(pc_load), 64'h1);
            check("t1_wait_pcin", 64'(pc_in), 64'(k));
            step();
            check("t1_valid", 64'(instr_valid), 64'h1);
            check("t1_instr_pc", 64'(instr_pc), 64'(k - 1));
            check("t1_instr", 64'(instr), 64'({16'hC0DE, 16'(k - 1)}));
            check("t1_addr", 64'(imem_addr), 64'(k));
        end

        // 2: decode stalled fills exactly DEPTH entries then holds pc
        hold_reset();
        release_reset();
        repeat (8) step();
        check("t2_full_req", 64'(imem_req), 64'h0);
        check("t2_full_load", 64'(pc_load), 64'h1);
        check("t2_full_pcin", 64'(pc_in), 64'h4);
        repeat (2) step();
        check("t2_still_req", 64'(imem_req), 64'h0);
        check("t2_still_pcin", 64'(pc_in), 64'h4);
        check("t2_head", 64'(instr_pc), 64'h0);
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2_drain_valid", 64'(instr_valid), 64'h1);
            check("t2_drain_pc", 64'(instr_pc), 64'(k));
            check("t2_drain_instr", 64'(instr), 64'({16'hC0DE, 16'(k)}));
            step();
        end

        // 3: redirect while waiting, late data discarded
        auto_en = 1'b0;
        hold_reset();
        instr_ready = 1'b1;
        release_reset();
        step();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        #1;
        check("t3_redir_load", 64'(pc_load), 64'h1);
        check("t3_redir_pcin", 64'(pc_in), 64'h40);
        check("t3_redir_req", 64'(imem_req), 64'h0);
        step();
        redirect = 1'b0;
        #1;
        check("t3_disc_req", 64'(imem_req), 64'h0);
        check("t3_disc_pcin", 64'(pc_in), 64'h40);
        step();
        man_rv   = 1'b1;
        man_data = 32'hDEAD_BEEF;
        #1;
        check("t3_late_req", 64'(imem_req), 64'h0);
        step();
        man_rv = 1'b0;
        #1;
        check("t3_dropped", 64'(instr_valid), 64'h0);
        check("t3_req", 64'(imem_req), 64'h1);
        check("t3_addr", 64'(imem_addr), 64'h40);

        // 4: redirect coincident with rvalid
        hold_reset();
        instr_ready = 1'b1;
        release_reset();
        step();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        man_rv      = 1'b1;
        man_data    = 32'h1234_5678;
        step();
        redirect = 1'b0;
        man_rv   = 1'b0;
        #1;
        check("t4_no_push", 64'(instr_valid), 64'h0);
        check("t4_req", 64'(imem_req), 64'h1);
        check("t4_addr", 64'(imem_addr), 64'h40);
        check("t4_advance", 64'(pc_load), 64'h0);

        // 5: async reset mid-flight, stray rvalid afterwards
        auto_en = 1'b1;
        hold_reset();
        release_reset();
        repeat (5) step();
        check("t5_pre_valid", 64'(instr_valid), 64'h1);
        check("t5_pre_wait", 64'(pc_load), 64'h1);
        reset = 1'b0;
        #1;
        check("t5_pc_load", 64'(pc_load), 64'h0);
        check("t5_pc_in", 64'(pc_in), 64'h0);
        check("t5_req", 64'(imem_req), 64'h0);
        check("t5_addr", 64'(imem_addr), 64'h0);
        check("t5_valid", 64'(instr_valid), 64'h0);
        check("t5_instr", 64'(instr), 64'h0);
        check("t5_instr_pc", 64'(instr_pc), 64'h0);
        auto_en = 1'b0;
        step();
        man_rv   = 1'b1;
        man_data = 32'hBAD0_BAD0;
        release_reset();
        check("t5_first_req", 64'(imem_req), 64'h1);
        check("t5_first_addr", 64'(imem_addr), 64'h0);
        step();
        man_rv = 1'b0;
        #1;
        check("t5_stray_ignored", 64'(instr_valid), 64'h0);
        man_rv   = 1'b1;
        man_data = 32'h0000_0055;
        step();
        man_rv = 1'b0;
        #1;
        check("t5_real_valid", 64'(instr_valid), 64'h1);
        check("t5_real_pc", 64'(instr_pc), 64'h0);
        check("t5_real_instr", 64'(instr), 64'h55);

        // 6: push and pop together at count=3, order kept across pointer wrap
        auto_en = 1'b1;
        hold_reset();
        release_reset();
        repeat (7) step();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        #1;
        check("t6_count3_req", 64'(imem_req), 64'h1);
        check("t6_count3_addr", 64'(imem_addr), 64'h4);
        check("t6_head", 64'(instr_pc), 64'h1);
        repeat (2) step();
        check("t6_full_req", 64'(imem_req), 64'h0);
        check("t6_full_pcin", 64'(pc_in), 64'h5);
        instr_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            #1;
            check("t6_order_valid", 64'(instr_valid), 64'h1);
            check("t6_order_pc", 64'(instr_pc), 64'(k));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
